// File: rtl/accelerator_tensor_pkg.sv
// Shared definitions for the tensor float datapath: FSM state encodings and
// single-bit constants used by the feeder, the index counter and, later, the
// tensor divider and collector.
package accelerator_tensor_pkg;

  typedef enum logic [1:0] {
    STARTER  = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2,
    ENDER    = 2'd3
  } tensor_state_t;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

endpackage

// File: rtl/accelerator_tensor_index_counter.sv
// Three-level nested i/j/k index counter (k fastest, then j, then i).
// clear zeroes all indices; advance steps one element in row-major order.
// Flags report the position of the current element within the tensor.
module accelerator_tensor_index_counter
  import accelerator_tensor_pkg::*;
#(
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [CONTROL_SIZE-1:0] size_i,
  input  logic [CONTROL_SIZE-1:0] size_j,
  input  logic [CONTROL_SIZE-1:0] size_k,
  output logic                    k_first,
  output logic                    jk_first,
  output logic                    last
);

  localparam logic [CONTROL_SIZE-1:0] CNT_ZERO = '0;
  localparam logic [CONTROL_SIZE-1:0] CNT_ONE  = {{(CONTROL_SIZE-1){ZERO}}, ONE};

  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [CONTROL_SIZE-1:0] k_q, k_d;
  logic                    i_wrap, j_wrap, k_wrap;

  // A level wraps when it sits on its last index (size - 1).
  assign k_wrap = (k_q == size_k - CNT_ONE);
  assign j_wrap = (j_q == size_j - CNT_ONE);
  assign i_wrap = (i_q == size_i - CNT_ONE);

  assign k_first  = (k_q == CNT_ZERO);
  assign jk_first = k_first && (j_q == CNT_ZERO);
  assign last     = i_wrap && j_wrap && k_wrap;

  // Next-index computation: carry ripples from k into j into i.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear) begin
      i_d = CNT_ZERO;
      j_d = CNT_ZERO;
      k_d = CNT_ZERO;
    end else if (advance) begin
      k_d = k_wrap ? CNT_ZERO : k_q + CNT_ONE;
      if (k_wrap) begin
        j_d = j_wrap ? CNT_ZERO : j_q + CNT_ONE;
        if (j_wrap) begin
          i_d = i_wrap ? CNT_ZERO : i_q + CNT_ONE;
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      i_q <= CNT_ZERO;
      j_q <= CNT_ZERO;
      k_q <= CNT_ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/accelerator_tensor_float_feeder.sv
// Operand feeder for the tensor float divider. Pulls elements from a
// valid/ready source in row-major order, presents each on DATA_OUT with
// I/J/K enable pulses, waits for NEXT per element and pulses READY at the end.
module accelerator_tensor_float_feeder
  import accelerator_tensor_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  input  logic [DATA_SIZE-1:0] SRC_DATA,
  input  logic                 NEXT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  tensor_state_t          state_q, state_d;
  logic [DATA_SIZE-1:0]   size_q [3];
  logic [DATA_SIZE-1:0]   size_d [3];
  logic [CONTROL_SIZE-1:0] size_c [3];
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   i_en_q, i_en_d;
  logic                   j_en_q, j_en_d;
  logic                   k_en_q, k_en_d;
  logic                   ready_q, ready_d;
  logic                   cnt_clear, cnt_advance;
  logic                   k_first, jk_first, last;
  logic                   any_size_zero;

  // Stored sizes are compared in the counter width; the cast zero-extends
  // or truncates as the two widths require.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_size
      assign size_c[gi] = CONTROL_SIZE'(size_q[gi]);
    end
  endgenerate

  assign any_size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);

  accelerator_tensor_index_counter #(
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_index (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .size_i  (size_c[0]),
    .size_j  (size_c[1]),
    .size_k  (size_c[2]),
    .k_first (k_first),
    .jk_first(jk_first),
    .last    (last)
  );

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    for (int n = 0; n < 3; n++) size_d[n] = size_q[n];
    i_en_d      = ZERO;
    j_en_d      = ZERO;
    k_en_d      = ZERO;
    ready_d     = ZERO;
    cnt_clear   = ZERO;
    cnt_advance = ZERO;
    case (state_q)
      STARTER: begin
        if (START) begin
          size_d[0] = SIZE_I_IN;
          size_d[1] = SIZE_J_IN;
          size_d[2] = SIZE_K_IN;
          if (any_size_zero) begin
            state_d = ENDER;
          end else begin
            cnt_clear = ONE;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (SRC_VALID) begin
          data_d  = SRC_DATA;
          k_en_d  = ONE;
          j_en_d  = k_first;
          i_en_d  = jk_first;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (NEXT) begin
          if (last) begin
            state_d = ENDER;
          end else begin
            cnt_advance = ONE;
            state_d     = LOAD;
          end
        end
      end
      ENDER: begin
        ready_d = ONE;
        state_d = STARTER;
      end
      default: state_d = STARTER;
    endcase
  end

  // State, stored sizes, output data and pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STARTER;
      for (int n = 0; n < 3; n++) size_q[n] <= '0;
      data_q  <= '0;
      i_en_q  <= ZERO;
      j_en_q  <= ZERO;
      k_en_q  <= ZERO;
      ready_q <= ZERO;
    end else begin
      state_q <= state_d;
      for (int n = 0; n < 3; n++) size_q[n] <= size_d[n];
      data_q  <= data_d;
      i_en_q  <= i_en_d;
      j_en_q  <= j_en_d;
      k_en_q  <= k_en_d;
      ready_q <= ready_d;
    end
  end

  assign SRC_READY         = (state_q == LOAD);
  assign READY             = ready_q;
  assign DATA_OUT          = data_q;
  assign DATA_OUT_I_ENABLE = i_en_q;
  assign DATA_OUT_J_ENABLE = j_en_q;
  assign DATA_OUT_K_ENABLE = k_en_q;

endmodule

// File: tb/tb_accelerator_tensor_float_feeder.sv
// Self-checking bench for accelerator_tensor_float_feeder: table of tensor
// runs driven through a scoreboard, plus hand-written zero-size and
// reset-during-run sequences.
module tb_accelerator_tensor_float_feeder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN, SIZE_J_IN, SIZE_K_IN;
  logic        SRC_VALID;
  logic        SRC_READY;
  logic [63:0] SRC_DATA;
  logic        NEXT;
  logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE;
  logic [63:0] DATA_OUT;

  accelerator_tensor_float_feeder #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .SIZE_I_IN        (SIZE_I_IN),
    .SIZE_J_IN        (SIZE_J_IN),
    .SIZE_K_IN        (SIZE_K_IN),
    .SRC_VALID        (SRC_VALID),
    .SRC_READY        (SRC_READY),
    .SRC_DATA         (SRC_DATA),
    .NEXT             (NEXT),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_OUT_K_ENABLE(DATA_OUT_K_ENABLE),
    .DATA_OUT         (DATA_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int si, sj, sk;
    int stall_elem, stall_len;   // SRC_VALID low before this element
    int hold_elem, hold_len;     // NEXT withheld after this element
    int start_elem;              // extra START during this element's WAIT_ACK
    int exp_elems;               // expected issued elements
    int exp_ready;               // expected READY pulses
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        i_en;
    logic        j_en;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom} | 64'h1;
  endfunction

  // Runs one tensor from a START at the current negedge until READY settles.
  task automatic run_tensor(input vec_t v);
    int n_acc, n_iss, ready_cnt, cyc, ready_cyc, final_next_cyc, stall_rem, hold_rem;
    bit waiting, refresh, done;
    logic [63:0] last_data;
    exp_t e;
    int ek, ej;
    n_acc = 0; n_iss = 0; ready_cnt = 0; cyc = 0;
    ready_cyc = -100; final_next_cyc = -1;
    stall_rem = v.stall_len; hold_rem = 0;
    waiting = 0; refresh = 0; done = 0; last_data = '0;
    sb.delete();
    START = 1'b1;
    SIZE_I_IN = 64'(v.si); SIZE_J_IN = 64'(v.sj); SIZE_K_IN = 64'(v.sk);
    SRC_VALID = 1'b1; NEXT = 1'b1; SRC_DATA = rnd64();
    while (!done) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      SIZE_I_IN = 64'(v.si); SIZE_J_IN = 64'(v.sj); SIZE_K_IN = 64'(v.sk);
      if (refresh) begin SRC_DATA = rnd64(); refresh = 0; end
      // Output side: every K pulse retires one scoreboard entry.
      if (DATA_OUT_K_ENABLE) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          $display("elem %0d data=%h i_en=%b j_en=%b", n_iss, DATA_OUT,
                   DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE);
          chk("data_out", DATA_OUT, e.data);
          chk("i_enable", 64'(DATA_OUT_I_ENABLE), 64'(e.i_en));
          chk("j_enable", 64'(DATA_OUT_J_ENABLE), 64'(e.j_en));
        end
        n_iss++;
        waiting = 1;
        last_data = DATA_OUT;
        hold_rem = (v.hold_elem == n_iss - 1) ? v.hold_len : 0;
        if (v.start_elem == n_iss - 1) begin
          START = 1'b1; SIZE_I_IN = 64'd3; SIZE_J_IN = 64'd3; SIZE_K_IN = 64'd3;
        end
      end else if (DATA_OUT_I_ENABLE || DATA_OUT_J_ENABLE) begin
        chk("stray_enable", {62'd0, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 64'd0);
      end
      if (READY) begin ready_cnt++; ready_cyc = cyc; end
      // Consumer acknowledge.
      if (waiting && hold_rem > 0) begin
        NEXT = 1'b0;
        hold_rem--;
        chk("hold_src_ready", 64'(SRC_READY), 64'd0);
        chk("hold_data_out", DATA_OUT, last_data);
      end else begin
        NEXT = 1'b1;
        if (waiting) begin
          waiting = 0;
          if (n_iss == v.exp_elems) final_next_cyc = cyc;
        end
      end
      // Source side: optional stall, then handshake pushes the expectation.
      if (n_acc == v.stall_elem && stall_rem > 0 && (SRC_READY || stall_rem < v.stall_len)) begin
        SRC_VALID = 1'b0;
        stall_rem--;
        chk("stall_src_ready", 64'(SRC_READY), 64'd1);
        chk("stall_data_out", DATA_OUT, last_data);
        chk("stall_k_enable", 64'(DATA_OUT_K_ENABLE), 64'd0);
      end else begin
        SRC_VALID = 1'b1;
      end
      if (SRC_VALID && SRC_READY) begin
        ek = n_acc % v.sk;
        ej = (n_acc / v.sk) % v.sj;
        e.data = SRC_DATA;
        e.j_en = (ek == 0);
        e.i_en = (ek == 0) && (ej == 0);
        sb.push_back(e);
        n_acc++;
        refresh = 1;
      end
      if (ready_cnt > 0 && cyc >= ready_cyc + 3) done = 1;
      if (cyc > 400) begin
        chk("run_timeout", 64'(cyc), 64'd400);
        done = 1;
      end
    end
    SRC_VALID = 1'b0; NEXT = 1'b0;
    chk("elements_issued", 64'(n_iss), 64'(v.exp_elems));
    chk("elements_accepted", 64'(n_acc), 64'(v.exp_elems));
    chk("ready_count", 64'(ready_cnt), 64'(v.exp_ready));
    chk("ready_after_next", 64'(ready_cyc - final_next_cyc), 64'd2);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[5];
  vec_t one_vec;
  int   seen, cyc;

  initial begin
    vecs[0] = '{si:2, sj:2, sk:2, stall_elem:-1, stall_len:0, hold_elem:-1, hold_len:0, start_elem:-1, exp_elems:8, exp_ready:1};
    vecs[1] = '{si:1, sj:1, sk:3, stall_elem:1,  stall_len:5, hold_elem:-1, hold_len:0, start_elem:-1, exp_elems:3, exp_ready:1};
    vecs[2] = '{si:1, sj:2, sk:2, stall_elem:-1, stall_len:0, hold_elem:0, hold_len:10, start_elem:-1, exp_elems:4, exp_ready:1};
    vecs[3] = '{si:2, sj:1, sk:1, stall_elem:-1, stall_len:0, hold_elem:-1, hold_len:0, start_elem:0,  exp_elems:2, exp_ready:1};
    vecs[4] = '{si:3, sj:1, sk:2, stall_elem:2,  stall_len:2, hold_elem:3, hold_len:3,  start_elem:-1, exp_elems:6, exp_ready:1};
    one_vec = '{si:1, sj:1, sk:1, stall_elem:-1, stall_len:0, hold_elem:-1, hold_len:0, start_elem:-1, exp_elems:1, exp_ready:1};

    RST = 1'b0; START = 1'b0; SRC_VALID = 1'b0; NEXT = 1'b0; SRC_DATA = '0;
    SIZE_I_IN = '0; SIZE_J_IN = '0; SIZE_K_IN = '0;
    repeat (3) @(negedge CLK);
    chk("reset_ready", 64'(READY), 64'd0);
    chk("reset_src_ready", 64'(SRC_READY), 64'd0);
    chk("reset_enables", {61'd0, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE}, 64'd0);
    chk("reset_data_out", DATA_OUT, 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    for (int t = 0; t < 5; t++) begin
      run_tensor(vecs[t]);
    end

    // Zero-sized J dimension: nothing issued, READY two cycles after START.
    START = 1'b1; SIZE_I_IN = 64'd2; SIZE_J_IN = 64'd0; SIZE_K_IN = 64'd2;
    SRC_VALID = 1'b1; NEXT = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("zero_ready", 64'(READY), (n == 2) ? 64'd1 : 64'd0);
      chk("zero_src_ready", 64'(SRC_READY), 64'd0);
      chk("zero_k_enable", 64'(DATA_OUT_K_ENABLE), 64'd0);
    end
    SRC_VALID = 1'b0; NEXT = 1'b0;

    // Reset during the third element of a 2x2x2 run, then a fresh 1x1x1.
    START = 1'b1; SIZE_I_IN = 64'd2; SIZE_J_IN = 64'd2; SIZE_K_IN = 64'd2;
    SRC_VALID = 1'b1; NEXT = 1'b1; SRC_DATA = rnd64();
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 100) begin
      @(negedge CLK);
      START = 1'b0;
      cyc++;
      if (DATA_OUT_K_ENABLE) seen++;
      if (!SRC_READY) SRC_DATA = rnd64();
    end
    chk("rst_run_elements", 64'(seen), 64'd3);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_ready", 64'(READY), 64'd0);
    chk("async_rst_src_ready", 64'(SRC_READY), 64'd0);
    chk("async_rst_enables", {61'd0, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE}, 64'd0);
    chk("async_rst_data_out", DATA_OUT, 64'd0);
    SRC_VALID = 1'b0; NEXT = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("in_rst_ready", 64'(READY), 64'd0);
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", {62'd0, READY, SRC_READY}, 64'd0);
    run_tensor(one_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
